// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and data-memory bus bundle for load_store_unit
// Purpose: carries the core-side req/ready/done handshake and the word-wide memory port.
// Modports:
//   slave  - the load/store unit: receives req/we/funct3/addr/wdata and mem_rd,
//            drives ready/done/rdata/err and mem_a/mem_wd/mem_we.
//   master - the environment (core plus memory): the mirror image of slave.
interface load_store_unit_if #(
   parameter int ADDR_W = 32
);
   logic              req;
   logic              we;
   logic [2:0]        funct3;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              ready;
   logic              done;
   logic [31:0]       rdata;
   logic              err;
   logic [ADDR_W-1:0] mem_a;
   logic [31:0]       mem_wd;
   logic              mem_we;
   logic [31:0]       mem_rd;

   modport slave (
      input  req, we, funct3, addr, wdata, mem_rd,
      output ready, done, rdata, err, mem_a, mem_wd, mem_we
   );

   modport master (
      output req, we, funct3, addr, wdata, mem_rd,
      input  ready, done, rdata, err, mem_a, mem_wd, mem_we
   );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RISC-V byte/halfword/word load-store unit over a word-only memory
// Purpose: turns core loads/stores into whole-word, big-endian memory accesses; sub-word
//          stores are done as read-modify-write.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - load_store_unit_if.slave: core req/we/funct3/addr/wdata -> ready/done/rdata/err,
//            memory mem_a/mem_wd/mem_we -> mem_rd (combinational read)
// Optional feature: define LSU_MISALIGN_TRAP_EN to return err for misaligned lh/lhu/sh/lw/sw
//                   instead of accessing the naturally aligned lane.
module load_store_unit #(
   parameter int ADDR_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   load_store_unit_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        off_q, off_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [ADDR_W-1:0] mem_a_q, mem_a_d;
   logic [31:0]       mem_wd_q, mem_wd_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              legal;
   logic              misalign;
   logic [7:0]        rd_byte;
   logic [15:0]       rd_half;
   logic [31:0]       load_val;
   logic [31:0]       merged;

   // Legality is judged on the live request inputs so the accept edge can branch directly.
   always_comb begin
      legal = 1'b0;
      if (bus.we) legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010);
      else        legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                          (bus.funct3 == 3'b100) || (bus.funct3 == 3'b101);
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                     ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   // Big-endian lanes: lowest byte address lives in bits 31:24.
   always_comb begin
      rd_byte = 8'h00;
      case (off_q)
         2'd0:    rd_byte = bus.mem_rd[31:24];
         2'd1:    rd_byte = bus.mem_rd[23:16];
         2'd2:    rd_byte = bus.mem_rd[15:8];
         default: rd_byte = bus.mem_rd[7:0];
      endcase
      rd_half = off_q[1] ? bus.mem_rd[15:0] : bus.mem_rd[31:16];
   end

   // funct3[2] selects zero extension (lbu/lhu); word loads ignore it.
   always_comb begin
      case (f3_q[1:0])
         2'b00:   load_val = {{24{rd_byte[7] & ~f3_q[2]}}, rd_byte};
         2'b01:   load_val = {{16{rd_half[15] & ~f3_q[2]}}, rd_half};
         default: load_val = bus.mem_rd;
      endcase
   end

   // Only sb/sh reach the merge, so anything that is not a byte op is a halfword op.
   always_comb begin
      merged = bus.mem_rd;
      if (f3_q[1:0] == 2'b00) begin
         case (off_q)
            2'd0:    merged = {wdata_q[7:0], bus.mem_rd[23:0]};
            2'd1:    merged = {bus.mem_rd[31:24], wdata_q[7:0], bus.mem_rd[15:0]};
            2'd2:    merged = {bus.mem_rd[31:16], wdata_q[7:0], bus.mem_rd[7:0]};
            default: merged = {bus.mem_rd[31:8], wdata_q[7:0]};
         endcase
      end else begin
         merged = off_q[1] ? {bus.mem_rd[31:16], wdata_q[15:0]} : {wdata_q[15:0], bus.mem_rd[15:0]};
      end
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      f3_d     = f3_q;
      off_d    = off_q;
      wdata_d  = wdata_q;
      mem_a_d  = mem_a_q;
      mem_wd_d = mem_wd_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (bus.req) begin
               we_d    = bus.we;
               f3_d    = bus.funct3;
               off_d   = bus.addr[1:0];
               wdata_d = bus.wdata;
               mem_a_d = {bus.addr[ADDR_W-1:2], 2'b00};
               err_d   = 1'b0;
               rdata_d = 32'h0;
               if (!legal || misalign) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else if (bus.we && (bus.funct3 == 3'b010)) begin
                  mem_wd_d = bus.wdata;
                  state_d  = WRITE;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            if (we_q) begin
               mem_wd_d = merged;
               state_d  = WRITE;
            end else begin
               rdata_d = load_val;
               state_d = DONE;
            end
         end
         WRITE:   state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         f3_q     <= 3'b000;
         off_q    <= 2'b00;
         wdata_q  <= 32'h0;
         mem_a_q  <= '0;
         mem_wd_q <= 32'h0;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         f3_q     <= f3_d;
         off_q    <= off_d;
         wdata_q  <= wdata_d;
         mem_a_q  <= mem_a_d;
         mem_wd_q <= mem_wd_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // mem_we decodes straight from state so an asserted reset kills it in the same cycle.
   assign bus.ready  = (state_q == IDLE);
   assign bus.done   = (state_q == DONE);
   assign bus.mem_we = (state_q == WRITE);
   assign bus.mem_a  = mem_a_q;
   assign bus.mem_wd = mem_wd_q;
   assign bus.rdata  = rdata_q;
   assign bus.err    = err_q;
endmodule
